audio_pwm_out: RTL and testbench

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

---
 rtl/audio_pwm_out.sv | 151 +++++++++++++++
 tb/tb_audio_pwm_out.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: buffers signed 8-bit filtered samples in a small FIFO,
// pops one per sample tick into an offset-binary hold register, and plays
// the held value out as an 8-bit PWM duty over 256-clock periods.
//
// Optional feature macro: AUDIO_PWM_VOLUME_EN
//   When defined, adds input volume[2:0]; each popped sample is
//   arithmetic-shifted right by volume before the offset-binary conversion.
//   When undefined, the port is absent and samples pass unscaled.
module audio_pwm_out #(
  parameter int SAMPLE_DIV = 2083,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic [7:0]                    sample_in,
`ifdef AUDIO_PWM_VOLUME_EN
  input  logic [2:0]                    volume,
`endif
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic          pwm_q, pwm_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          tick;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic [7:0]    head;
  logic [7:0]    head_scaled;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_FULL);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write on a tick.
  assign pop        = tick & ~fifo_empty;
  assign push       = sample_valid & (~fifo_full | pop);
  assign head       = mem_q[rd_ptr_q];

`ifdef AUDIO_PWM_VOLUME_EN
  assign head_scaled = 8'($signed(head) >>> volume);
`else
  assign head_scaled = head;
`endif

  // Next-state for FIFO bookkeeping, tick timer, hold/duty and PWM output.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tick_cnt_d = tick_cnt_q + TW'(1);
    hold_d     = hold_q;
    duty_d     = duty_q;
    pwm_cnt_d  = pwm_cnt_q + 8'd1;
    pwm_d      = (pwm_cnt_q < duty_q);
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (tick) begin
      tick_cnt_d = '0;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      hold_d   = head_scaled ^ 8'h80;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (sample_valid && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end

    if (tick && fifo_empty) begin
      unf_d = 1'b1;
    end

    // Duty only changes at the period boundary so every period is a whole duty cycle.
    if (pwm_cnt_q == 8'hFF) begin
      duty_d = hold_q;
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tick_cnt_q <= '0;
      hold_q     <= 8'h80;
      duty_q     <= 8'h80;
      pwm_cnt_q  <= 8'd0;
      pwm_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Sample storage; reset empties the FIFO through the pointers, not the contents.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign pwm_out    = pwm_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Testbench for audio_pwm_out: directed scenarios plus a randomized run,
// all checked against a sample-level reference model (queue + cycle count).
module tb_audio_pwm_out;

  localparam int DIV   = 600;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_in = 8'h00;
`ifdef AUDIO_PWM_VOLUME_EN
  logic [2:0] volume = 3'd0;
`endif
  logic       pwm_out;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  audio_pwm_out #(.SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
`ifdef AUDIO_PWM_VOLUME_EN
    .volume       (volume),
`endif
    .pwm_out      (pwm_out),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // n_m counts clocks since reset; ticks fall on n % DIV == DIV-1 and
  // PWM periods on n % 256. Samples live in a plain queue.
  int         n_m = 0;
  logic [7:0] q_m[$];
  logic [7:0] hold_m = 8'h80, duty_m = 8'h80, new_hold_m, s_m;
  logic       pwm_m = 1'b0, ovf_m = 1'b0, unf_m = 1'b0;
  int         pops_m = 0;
  int         last_pop_n = -1000;
  int         shift_m;

  function automatic logic [7:0] scale(input logic [7:0] s, input int sh);
    int v, d, r;
    v = (s >= 8'd128) ? int'(s) - 256 : int'(s);
    d = 1 << sh;
    r = (v >= 0) ? v / d : -((-v + d - 1) / d);
    return 8'(r);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      q_m.delete();
      n_m = 0; hold_m = 8'h80; duty_m = 8'h80;
      pwm_m = 1'b0; ovf_m = 1'b0; unf_m = 1'b0;
      last_pop_n = -1000;
    end else begin
`ifdef AUDIO_PWM_VOLUME_EN
      shift_m = int'(volume);
`else
      shift_m = 0;
`endif
      new_hold_m = hold_m;
      if (n_m % DIV == DIV - 1) begin
        if (q_m.size() == 0) unf_m = 1'b1;
        else begin
          s_m = q_m.pop_front();
          new_hold_m = scale(s_m, shift_m) ^ 8'h80;
          pops_m++;
          last_pop_n = n_m;
        end
      end
      if (sample_valid) begin
        if (q_m.size() < DEPTH) q_m.push_back(sample_in);
        else ovf_m = 1'b1;
      end
      pwm_m = ((n_m % 256) < int'(duty_m));
      if (n_m % 256 == 255) duty_m = hold_m;
      hold_m = new_hold_m;
      n_m++;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    sample_valid = 1'b1;
    sample_in = v;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic wait_pop(input int prev, output bit ok);
    int k = 0;
    ok = 1'b1;
    while (pops_m == prev) begin
      @(negedge clock);
      k++;
      if (k > 3 * DIV) begin ok = 1'b0; return; end
    end
  endtask

  // Count high clocks over the first full PWM period whose duty was loaded after the last pop.
  task automatic measure(output int highs, output bit ok);
    int k = 0;
    ok = 1'b1;
    highs = 0;
    while (!((n_m % 256) == 1 && (n_m - 1) >= last_pop_n + 2)) begin
      @(negedge clock);
      k++;
      if (k > 700) begin ok = 1'b0; return; end
    end
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clock);
      highs += int'(pwm_out);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'h55;
    repeat (3) @(negedge clock);
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
    reset = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic test_idle;
    int highs;
    for (int p = 0; p < 4; p++) begin
      highs = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge clock);
        highs += int'(pwm_out);
        checks++; if (pwm_out !== pwm_m) begin failures++; $display("FAIL idle_pwm n=%0d got=%b exp=%b", n_m, pwm_out, pwm_m); end
      end
      checks++; if (highs != 128) begin failures++; $display("FAIL idle_highs period=%0d got=%0d exp=128", p, highs); end
    end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL idle_level got=%0d exp=0", fifo_level); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL idle_underflow got=%b exp=1", underflow); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL idle_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_extremes;
    int highs, prev;
    bit ok;
    prev = pops_m;
    pulse(8'h7F);
    wait_pop(prev, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ext_pop7f timeout got=none exp=pop"); end
    measure(highs, ok);
    checks++; if (!ok || highs != 255) begin failures++; $display("FAIL ext_duty_ff got=%0d exp=255", highs); end
    prev = pops_m;
    pulse(8'h80);
    wait_pop(prev, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ext_pop80 timeout got=none exp=pop"); end
    measure(highs, ok);
    checks++; if (!ok || highs != 0) begin failures++; $display("FAIL ext_duty_00 got=%0d exp=0", highs); end
  endtask

  task automatic test_overflow;
    logic [7:0] v[5];
    int highs, prev, k;
    bit ok;
    k = 0;
    while (n_m % DIV != 1 && k < 2 * DIV) begin @(negedge clock); k++; end
    for (int i = 0; i < 5; i++) v[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in = v[i];
      @(negedge clock);
    end
    sample_valid = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      prev = pops_m;
      wait_pop(prev, ok);
      measure(highs, ok);
      checks++; if (!ok || highs != int'(v[i] ^ 8'h80)) begin failures++; $display("FAIL ovf_order idx=%0d got=%0d exp=%0d", i, highs, v[i] ^ 8'h80); end
    end
  endtask

  task automatic test_full_tick;
    logic [7:0] x;
    int highs, prev, k;
    bit ok;
    do_reset(2);
    for (int i = 0; i < 4; i++) pulse(8'($urandom_range(0, 255)));
    k = 0;
    while (n_m % DIV != DIV - 1 && k < 2 * DIV) begin @(negedge clock); k++; end
    x = 8'($urandom_range(0, 255));
    pulse(x);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL fulltick_level got=%0d exp=4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fulltick_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      prev = pops_m;
      wait_pop(prev, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fulltick_pop idx=%0d got=none exp=pop", i); end
    end
    measure(highs, ok);
    checks++; if (!ok || highs != int'(x ^ 8'h80)) begin failures++; $display("FAIL fulltick_newest got=%0d exp=%0d", highs, x ^ 8'h80); end
  endtask

  task automatic test_reset_mid;
    int highs, k;
    bit ok;
    k = 0;
    while (underflow !== 1'b1 && k < 2 * DIV) begin @(negedge clock); k++; end
    for (int i = 0; i < 3; i++) pulse(8'($urandom_range(0, 255)));
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL rmid_pre_level got=%0d exp=3", fifo_level); end
    do_reset(1);
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", fifo_level); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL rmid_flags got=%b exp=00", {overflow, underflow}); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rmid_pwm got=%b exp=0", pwm_out); end
    measure(highs, ok);
    checks++; if (!ok || highs != 128) begin failures++; $display("FAIL rmid_duty got=%0d exp=128", highs); end
  endtask

  task automatic test_volume;
    int highs, prev, expv;
    bit ok;
    do_reset(2);
`ifdef AUDIO_PWM_VOLUME_EN
    volume = 3'd2;
    expv = 8'h90;
`else
    expv = 8'hC0;
`endif
    prev = pops_m;
    pulse(8'h40);
    wait_pop(prev, ok);
    measure(highs, ok);
    checks++; if (!ok || highs != expv) begin failures++; $display("FAIL volume_duty got=%0d exp=%0d", highs, expv); end
`ifdef AUDIO_PWM_VOLUME_EN
    volume = 3'd0;
`endif
  endtask

  task automatic test_random;
    do_reset(2);
    for (int i = 0; i < 6000 && failures < 40; i++) begin
      sample_valid = ($urandom_range(0, (i < 3000) ? 299 : 1199) == 0);
      sample_in = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 2499) == 0);
`ifdef AUDIO_PWM_VOLUME_EN
      if ($urandom_range(0, 199) == 0) volume = 3'($urandom_range(0, 7));
`endif
      @(negedge clock);
      checks++; if (pwm_out !== pwm_m) begin failures++; $display("FAIL rnd_pwm i=%0d got=%b exp=%b", i, pwm_out, pwm_m); end
      checks++; if (fifo_level !== 3'(q_m.size())) begin failures++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, fifo_level, q_m.size()); end
      checks++; if (overflow !== ovf_m) begin failures++; $display("FAIL rnd_overflow i=%0d got=%b exp=%b", i, overflow, ovf_m); end
      checks++; if (underflow !== unf_m) begin failures++; $display("FAIL rnd_underflow i=%0d got=%b exp=%b", i, underflow, unf_m); end
    end
    reset = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_extremes();
    test_overflow();
    test_full_tick();
    test_reset_mid();
    test_volume();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
